// File: rtl/exec_mul_ctrl.sv
// Iterative signed shift-add multiplier for the exec stage: WIDTH RUN cycles,
// one sign-fix cycle, then a one-cycle done pulse with the low product word.
module exec_mul_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    flush,
  input  logic signed [WIDTH-1:0] src1,
  input  logic signed [WIDTH-1:0] src2,
  output logic                    busy,
  output logic                    done,
  output logic        [WIDTH-1:0] out,
  output logic                    overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

  state_t               state_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic                 neg_q;
  logic [CW-1:0]        count_q;
  logic                 done_q;
  logic [WIDTH-1:0]     out_q;
  logic                 ovf_q;

  logic                 accept_d;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   fin_d;

  // Magnitude as unsigned; the most negative value maps onto itself.
  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return u[WIDTH-1] ? (~u + 1'b1) : u;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2(input logic [2*WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  assign accept_d = start & ~flush & ((state_q == IDLE) | (state_q == DONE));
  assign acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign fin_d    = neg_q ? neg2(acc_q) : acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      count_q  <= '0;
      done_q   <= 1'b0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (accept_d) begin
              mcand_q  <= {{WIDTH{1'b0}}, abs_val(src1)};
              mplier_q <= abs_val(src2);
              neg_q    <= src1[WIDTH-1] ^ src2[WIDTH-1];
              acc_q    <= '0;
              count_q  <= '0;
              state_q  <= RUN;
            end else begin
              state_q  <= IDLE;
            end
          end
          RUN: begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + 1'b1;
            if (count_q == LAST) state_q <= SIGN;
          end
          SIGN: begin
            acc_q   <= fin_d;
            out_q   <= fin_d[WIDTH-1:0];
            ovf_q   <= (fin_d[2*WIDTH-1:WIDTH] != {WIDTH{fin_d[WIDTH-1]}});
            done_q  <= 1'b1;
            state_q <= DONE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Stall covers the accept cycle plus every RUN and SIGN cycle.
  assign busy     = ~reset & (accept_d | (state_q == RUN) | (state_q == SIGN));
  assign done     = done_q;
  assign out      = out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_exec_mul_ctrl.sv
// Directed bench for exec_mul_ctrl with hand-computed products and timing.
module tb_exec_mul_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  exec_mul_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .src1(src1), .src2(src2),
    .busy(busy), .done(done), .out(out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles (sampling mid-cycle) and tally busy/done highs.
  task automatic run_cycles(input int n, output int nb, output int nd);
    nb = 0;
    nd = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      nb += int'(busy);
      nd += int'(done);
    end
  endtask

  task automatic mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eo, input logic ev);
    int nb, nd;
    @(negedge clk);
    src1 = a; src2 = b; start = 1'b1;
    #1 chk({tag, "_busy_c"}, busy, 1);
    run_cycles(33, nb, nd);
    chk({tag, "_busy_run"}, nb, 33);
    chk({tag, "_nodone_run"}, nd, 0);
    @(negedge clk); #1;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_out"}, out, eo);
    chk({tag, "_ovf"}, overflow, ev);
    @(negedge clk); #1;
    chk({tag, "_done_once"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb, nd;
    reset = 1'b1; start = 1'b0; flush = 1'b0; src1 = '0; src2 = '0;
    #1;
    chk("rst_out", out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    mul("m3x5", 32'd3, 32'd5, 32'd15, 1'b0);
    mul("mneg7x6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0);
    mul("mneg4xneg5", 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'd20, 1'b0);
    mul("m64k", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    mul("mmin", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

    // Back-to-back: second request presented during the first DONE cycle.
    @(negedge clk);
    src1 = 32'd2; src2 = 32'd3; start = 1'b1;
    #1 chk("b2b_busy_c", busy, 1);
    run_cycles(33, nb, nd);
    chk("b2b_busy1", nb, 33);
    chk("b2b_nodone1", nd, 0);
    @(negedge clk);
    src1 = 32'd4; src2 = 32'd5; start = 1'b1;
    #1;
    chk("b2b_done1", done, 1);
    chk("b2b_out1", out, 6);
    run_cycles(33, nb, nd);
    chk("b2b_busy2", nb, 33);
    chk("b2b_nodone2", nd, 0);
    @(negedge clk); #1;
    chk("b2b_done2", done, 1);
    chk("b2b_busy_done2", busy, 0);
    chk("b2b_out2", out, 20);

    // Flush mid-run after a known result of 15.
    mul("pre_flush", 32'd3, 32'd5, 32'd15, 1'b0);
    @(negedge clk);
    src1 = 32'd7; src2 = 32'd9; start = 1'b1;
    run_cycles(9, nb, nd);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fl_busy", busy, 0);
    chk("fl_done", done, 0);
    run_cycles(30, nb, nd);
    chk("fl_busy_after", nb, 0);
    chk("fl_nodone", nd, 0);
    chk("fl_out_held", out, 15);
    chk("fl_ovf_held", overflow, 0);

    // Flush beats start in IDLE.
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    #1 chk("flst_busy", busy, 0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1 chk("flst_not_run", busy, 0);

    // Asynchronous reset mid-run, then a clean multiply.
    mul("pre_rst", 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
    mul("pre_rst2", 32'd3, 32'd5, 32'd15, 1'b0);
    @(negedge clk);
    src1 = 32'd11; src2 = 32'd13; start = 1'b1;
    run_cycles(19, nb, nd);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ar_out", out, 0);
    chk("ar_ovf", overflow, 0);
    chk("ar_done", done, 0);
    chk("ar_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    run_cycles(20, nb, nd);
    chk("ar_nodone", nd, 0);
    chk("ar_idle", nb, 0);
    mul("post_rst", 32'd3, 32'd5, 32'd15, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
